// File: rtl/dec_scan_pkg.sv
// dec_scan_pkg: shared state/mode encodings and decoder enable codes for the LED scan sequencer.
package dec_scan_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    typedef enum logic [1:0] {M_UP, M_DOWN, M_PINGPONG, M_SWEEP} mode_t;
    localparam logic [2:0] EN_ON  = 3'b100;
    localparam logic [2:0] EN_OFF = 3'b000;
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: counts 0..term while enabled and pulses tick on the terminal count; clear forces 0.
module step_prescaler #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tick
);
    logic [W-1:0] cnt;
    assign tick = en & ~clear & (cnt == term);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en) cnt <= (cnt == term) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: scans a 3-to-8 active-low LED decoder in four modes with a one-shot host override.
module decoder_scan_ctrl
    import dec_scan_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int HOLD_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic       req_valid,
    input  logic [2:0] req_sel,
    output logic       req_ready,
    output logic [2:0] switch,
    output logic [2:0] enable,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(DIV) + 1;
    localparam int HW = $clog2(HOLD_CYC) + 1;
    localparam logic [CW-1:0] DIV_T  = CW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_T = HW'(HOLD_CYC - 1);

    state_t     state, ret;
    mode_t      mode_q;
    logic       dir, sv_dir, nxt_dir, sweep_end, accept, step, hold_end;
    logic [2:0] sv_switch, nxt_sel;

    assign req_ready = state != HOLD;
    assign accept    = req_valid & req_ready;
    assign sweep_end = mode_q == M_SWEEP && switch == 3'd7;
    // dir only matters for PINGPONG: it flips when the walk reaches either endpoint
    assign nxt_dir   = mode_q == M_PINGPONG ? (dir ? switch != 3'd7 : switch == 3'd0) : dir;
    assign nxt_sel   = (mode_q == M_DOWN || (mode_q == M_PINGPONG && !nxt_dir)) ? switch - 3'd1 : switch + 3'd1;

    step_prescaler #(.W(CW)) u_scan_div (
        .clk(clk), .rst(rst), .clear(state != SCAN || accept || stop),
        .en(state == SCAN), .term(DIV_T), .tick(step)
    );

    step_prescaler #(.W(HW)) u_hold_div (
        .clk(clk), .rst(rst), .clear(state != HOLD),
        .en(state == HOLD), .term(HOLD_T), .tick(hold_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ret       <= IDLE;
            mode_q    <= M_UP;
            switch    <= 3'd0;
            enable    <= EN_OFF;
            busy      <= 1'b0;
            done      <= 1'b0;
            dir       <= 1'b1;
            sv_switch <= 3'd0;
            sv_dir    <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= HOLD;
                        ret       <= IDLE;
                        sv_switch <= switch;
                        sv_dir    <= dir;
                        switch    <= req_sel;
                        enable    <= EN_ON;
                        busy      <= 1'b1;
                    end else if (start) begin
                        state  <= SCAN;
                        mode_q <= mode_t'(mode);
                        switch <= mode_t'(mode) == M_DOWN ? 3'd7 : 3'd0;
                        dir    <= 1'b1;
                        enable <= EN_ON;
                        busy   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        state     <= HOLD;
                        ret       <= stop ? IDLE : SCAN;
                        sv_switch <= switch;
                        sv_dir    <= dir;
                        switch    <= req_sel;
                    end else if (stop || (step && sweep_end)) begin
                        state  <= IDLE;
                        switch <= 3'd0;
                        enable <= EN_OFF;
                        busy   <= 1'b0;
                        done   <= !stop;
                    end else if (step) begin
                        switch <= nxt_sel;
                        dir    <= nxt_dir;
                    end
                end
                default: begin
                    if (stop) ret <= IDLE;
                    if (hold_end) begin
                        if (ret == IDLE || stop) begin
                            state  <= IDLE;
                            switch <= 3'd0;
                            enable <= EN_OFF;
                            busy   <= 1'b0;
                        end else begin
                            state  <= SCAN;
                            switch <= sv_switch;
                            dir    <= sv_dir;
                        end
                    end
                end
            endcase
        end
    end
endmodule
